// File: rtl/bfly_2p_pipe_if.sv
// Stream interface for the radix-2 butterfly: operand side and result side,
// each with its own valid/ready handshake.
interface bfly_2p_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int OUT_WIDTH  = 17
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          inv;
    logic                          scale;
    logic signed [DATA_WIDTH-1:0]  A_real;
    logic signed [DATA_WIDTH-1:0]  A_imag;
    logic signed [DATA_WIDTH-1:0]  B_real;
    logic signed [DATA_WIDTH-1:0]  B_imag;
    logic signed [TW_WIDTH-1:0]    W_real;
    logic signed [TW_WIDTH-1:0]    W_imag;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   Y0_real;
    logic signed [OUT_WIDTH-1:0]   Y0_imag;
    logic signed [OUT_WIDTH-1:0]   Y1_real;
    logic signed [OUT_WIDTH-1:0]   Y1_imag;
    logic                          ovf;

    modport master (
        output in_valid, inv, scale, A_real, A_imag, B_real, B_imag, W_real, W_imag, out_ready,
        input  in_ready, out_valid, Y0_real, Y0_imag, Y1_real, Y1_imag, ovf
    );

    modport slave (
        input  in_valid, inv, scale, A_real, A_imag, B_real, B_imag, W_real, W_imag, out_ready,
        output in_ready, out_valid, Y0_real, Y0_imag, Y1_real, Y1_imag, ovf
    );
endinterface

// File: rtl/bfly_2p_pipe.sv
// Three-stage radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W, with optional
// conjugate twiddle, 1/2 scaling, rounding and output saturation.
module bfly_2p_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int OUT_WIDTH  = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    bfly_2p_pipe_if.slave bus
);
    localparam int MW = DATA_WIDTH + TW_WIDTH;   // single product
    localparam int PW = MW + 1;                  // sum/difference of two products
    localparam int SW = PW + 2;                  // A +/- P with headroom
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_WIDTH - 2);

    logic stall;

    // stage 1 registers
    logic                         v1_q, inv1_q, scale1_q;
    logic signed [DATA_WIDTH-1:0] ar1_q, ai1_q, br1_q, bi1_q;
    logic signed [TW_WIDTH-1:0]   wr1_q, wi1_q;

    // stage 2 registers
    logic                         v2_q, inv2_q, scale2_q;
    logic signed [DATA_WIDTH-1:0] ar2_q, ai2_q;
    logic signed [MW-1:0]         rr_q, ii_q, ri_q, ir_q;

    // stage 3 registers
    logic                         v3_q, ovf_q;
    logic signed [OUT_WIDTH-1:0]  y0r_q, y0i_q, y1r_q, y1i_q;

    // stage 3 combinational results
    logic signed [PW-1:0]         p_re, p_im;
    logic signed [SW-1:0]         s0r, s0i, s1r, s1i;
    logic signed [OUT_WIDTH-1:0]  y0r_d, y0i_d, y1r_d, y1i_d;
    logic                         c0r, c0i, c1r, c1i;

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [SW-1:0] x,
                                                         output logic clip);
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi   = SW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
        lo   = ~hi;
        clip = 1'b0;
        sat  = x[OUT_WIDTH-1:0];
        if (x > hi) begin
            clip = 1'b1;
            sat  = hi[OUT_WIDTH-1:0];
        end else if (x < lo) begin
            clip = 1'b1;
            sat  = lo[OUT_WIDTH-1:0];
        end
    endfunction

    // every stage advances together unless the result slot is full and blocked
    assign stall        = v3_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // S1: capture operands and per-operation mode bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            inv1_q   <= 1'b0;
            scale1_q <= 1'b0;
            ar1_q    <= '0;
            ai1_q    <= '0;
            br1_q    <= '0;
            bi1_q    <= '0;
            wr1_q    <= '0;
            wi1_q    <= '0;
        end else if (!stall) begin
            v1_q     <= bus.in_valid;
            inv1_q   <= bus.inv;
            scale1_q <= bus.scale;
            ar1_q    <= bus.A_real;
            ai1_q    <= bus.A_imag;
            br1_q    <= bus.B_real;
            bi1_q    <= bus.B_imag;
            wr1_q    <= bus.W_real;
            wi1_q    <= bus.W_imag;
        end
    end

    // S2: four full-width signed partial products, A forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            inv2_q   <= 1'b0;
            scale2_q <= 1'b0;
            ar2_q    <= '0;
            ai2_q    <= '0;
            rr_q     <= '0;
            ii_q     <= '0;
            ri_q     <= '0;
            ir_q     <= '0;
        end else if (!stall) begin
            v2_q     <= v1_q;
            inv2_q   <= inv1_q;
            scale2_q <= scale1_q;
            ar2_q    <= ar1_q;
            ai2_q    <= ai1_q;
            rr_q     <= br1_q * wr1_q;
            ii_q     <= bi1_q * wi1_q;
            ri_q     <= br1_q * wi1_q;
            ir_q     <= bi1_q * wr1_q;
        end
    end

    // S3 datapath: combine products (conj(W) folded into signs), round, add/sub, scale, clamp
    always_comb begin
        if (inv2_q) begin
            p_re = PW'(rr_q) + PW'(ii_q);
            p_im = PW'(ir_q) - PW'(ri_q);
        end else begin
            p_re = PW'(rr_q) - PW'(ii_q);
            p_im = PW'(ri_q) + PW'(ir_q);
        end
        p_re = (p_re + RND) >>> (TW_WIDTH - 1);
        p_im = (p_im + RND) >>> (TW_WIDTH - 1);
        s0r  = SW'(ar2_q) + SW'(p_re);
        s0i  = SW'(ai2_q) + SW'(p_im);
        s1r  = SW'(ar2_q) - SW'(p_re);
        s1i  = SW'(ai2_q) - SW'(p_im);
        if (scale2_q) begin
            s0r = (s0r + SW'(1)) >>> 1;
            s0i = (s0i + SW'(1)) >>> 1;
            s1r = (s1r + SW'(1)) >>> 1;
            s1i = (s1i + SW'(1)) >>> 1;
        end
        y0r_d = sat(s0r, c0r);
        y0i_d = sat(s0i, c0i);
        y1r_d = sat(s1r, c1r);
        y1i_d = sat(s1i, c1i);
    end

    // S3 output register; ovf only reflects slots that carry a real operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q  <= 1'b0;
            ovf_q <= 1'b0;
            y0r_q <= '0;
            y0i_q <= '0;
            y1r_q <= '0;
            y1i_q <= '0;
        end else if (!stall) begin
            v3_q  <= v2_q;
            ovf_q <= v2_q & (c0r | c0i | c1r | c1i);
            y0r_q <= y0r_d;
            y0i_q <= y0i_d;
            y1r_q <= y1r_d;
            y1i_q <= y1i_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.ovf       = ovf_q;
    assign bus.Y0_real   = y0r_q;
    assign bus.Y0_imag   = y0i_q;
    assign bus.Y1_real   = y1r_q;
    assign bus.Y1_imag   = y1i_q;
endmodule

// File: tb/tb_bfly_2p_pipe.sv
// Directed bench for bfly_2p_pipe: one 17-bit-output instance for the main
// checks and a 16-bit-output instance sharing the same stimulus for clamping.
module tb_bfly_2p_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic in_valid = 1'b0;
    logic inv = 1'b0;
    logic scale = 1'b0;
    logic out_ready = 1'b1;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;

    bfly_2p_pipe_if #(.DATA_WIDTH(16), .TW_WIDTH(16), .OUT_WIDTH(17)) ifc ();
    bfly_2p_pipe_if #(.DATA_WIDTH(16), .TW_WIDTH(16), .OUT_WIDTH(16)) ifc16 ();

    assign ifc.in_valid    = in_valid;
    assign ifc.inv         = inv;
    assign ifc.scale       = scale;
    assign ifc.A_real      = a_re;
    assign ifc.A_imag      = a_im;
    assign ifc.B_real      = b_re;
    assign ifc.B_imag      = b_im;
    assign ifc.W_real      = w_re;
    assign ifc.W_imag      = w_im;
    assign ifc.out_ready   = out_ready;
    assign ifc16.in_valid  = in_valid;
    assign ifc16.inv       = inv;
    assign ifc16.scale     = scale;
    assign ifc16.A_real    = a_re;
    assign ifc16.A_imag    = a_im;
    assign ifc16.B_real    = b_re;
    assign ifc16.B_imag    = b_im;
    assign ifc16.W_real    = w_re;
    assign ifc16.W_imag    = w_im;
    assign ifc16.out_ready = out_ready;

    bfly_2p_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16), .OUT_WIDTH(17)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
    bfly_2p_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16), .OUT_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(ifc16)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input logic iv, input logic sc);
        a_re = 16'(ar); a_im = 16'(ai);
        b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        inv = iv; scale = sc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!ifc.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_timeout", ifc.out_valid, 1);
    endtask

    task automatic chk_res(input string tag, input int y0r, input int y0i, input int y1r,
                           input int y1i, input logic ov);
        chk({tag, "_y0r"}, ifc.Y0_real, y0r);
        chk({tag, "_y0i"}, ifc.Y0_imag, y0i);
        chk({tag, "_y1r"}, ifc.Y1_real, y1r);
        chk({tag, "_y1i"}, ifc.Y1_imag, y1i);
        chk({tag, "_ovf"}, ifc.ovf, ov);
    endtask

    task automatic chk_res16(input string tag, input int y0r, input int y0i, input int y1r,
                             input int y1i, input logic ov);
        chk({tag, "_v16"}, ifc16.out_valid, 1);
        chk({tag, "_y0r16"}, ifc16.Y0_real, y0r);
        chk({tag, "_y0i16"}, ifc16.Y0_imag, y0i);
        chk({tag, "_y1r16"}, ifc16.Y1_real, y1r);
        chk({tag, "_y1i16"}, ifc16.Y1_imag, y1i);
        chk({tag, "_ovf16"}, ifc16.ovf, ov);
    endtask

    int idx, rcv, nout;
    logic stalled_prev;
    logic signed [16:0] held0, held1;

    initial begin
        // reset state
        #1;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_ovf", ifc.ovf, 0);
        chk("rst_y0r", ifc.Y0_real, 0);
        chk("rst_y1i", ifc.Y1_imag, 0);
        chk("rst_in_ready", ifc.in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // identity with exact latency: captured at first edge, valid after the third
        apply(100, 0, 50, 0, 'h7FFF, 0, 1'b0, 1'b0);
        chk("lat_e1", ifc.out_valid, 0);
        @(posedge clk); #1;
        chk("lat_e2", ifc.out_valid, 0);
        @(posedge clk); #1;
        chk("lat_e3", ifc.out_valid, 1);
        chk_res("ident", 150, 0, 50, 0, 1'b0);
        @(posedge clk); #1;
        chk("ident_single", ifc.out_valid, 0);

        // rotation by j, forward and conjugate
        apply(0, 0, 1000, 0, 0, 'h7FFF, 1'b0, 1'b0);
        wait_out();
        chk_res("rot_fwd", 0, 1000, 0, -1000, 1'b0);
        apply(0, 0, 1000, 0, 0, 'h7FFF, 1'b1, 1'b0);
        wait_out();
        chk_res("rot_inv", 0, -1000, 0, 1000, 1'b0);

        // halving with round-half-up
        apply(101, 0, 100, 0, 'h7FFF, 0, 1'b0, 1'b1);
        wait_out();
        chk_res("scale", 101, 0, 1, 0, 1'b0);

        // near-full-scale: 32767*0x7FFF rounds to 32766; clamps only on 16-bit outputs
        apply(32767, -32768, 32767, 32767, 'h7FFF, 0, 1'b0, 1'b0);
        wait_out();
        chk_res("sat17", 65533, -2, 1, -65534, 1'b0);
        chk_res16("sat16", 32767, -2, 1, -32768, 1'b1);

        // W = -1.0 with most-negative operands: no internal wrap
        apply(-32768, -32768, -32768, -32768, -32768, 0, 1'b0, 1'b0);
        wait_out();
        chk_res("wneg17", 0, 0, -65536, -65536, 1'b0);
        chk_res16("wneg16", 0, 0, -32768, -32768, 1'b1);
        @(posedge clk); #1;

        // backpressure: 8 back-to-back sets, out_ready low in cycles 2..6
        idx = 0; rcv = 0; stalled_prev = 1'b0; held0 = '0; held1 = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            if (idx < 8) begin
                in_valid = 1'b1;
                a_re = 16'(idx * 10 + 1); a_im = '0;
                b_re = 16'(idx); b_im = '0;
                w_re = 16'h7FFF; w_im = '0;
                inv = 1'b0; scale = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_in_ready", ifc.in_ready, (c >= 3 && c <= 6) ? 0 : 1);
            if (stalled_prev) begin
                chk("bp_hold_valid", ifc.out_valid, 1);
                chk("bp_hold_y0r", ifc.Y0_real, held0);
                chk("bp_hold_y1r", ifc.Y1_real, held1);
            end
            stalled_prev = ifc.out_valid && !out_ready;
            held0 = ifc.Y0_real;
            held1 = ifc.Y1_real;
            if (ifc.out_valid && out_ready) begin
                chk("bp_y0r", ifc.Y0_real, 11 * rcv + 1);
                chk("bp_y1r", ifc.Y1_real, 9 * rcv + 1);
                rcv++;
            end
            if (in_valid && ifc.in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", idx, 8);
        chk("bp_count", rcv, 8);

        // reset with three results in flight
        apply(1, 0, 0, 0, 'h7FFF, 0, 1'b0, 1'b0);
        apply(2, 0, 0, 0, 'h7FFF, 0, 1'b0, 1'b0);
        apply(3, 0, 0, 0, 'h7FFF, 0, 1'b0, 1'b0);
        chk("inflight_valid", ifc.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ifc.out_valid, 0);
        chk("midrst_y0r", ifc.Y0_real, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apply(7, 0, 0, 0, 'h7FFF, 0, 1'b0, 1'b0);
        nout = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.out_valid) begin
                nout++;
                chk_res("post_rst", 7, 0, 7, 0, 1'b0);
            end
            @(posedge clk); #1;
        end
        chk("post_rst_count", nout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
